hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 Rn_ID, Rm_ID  in  5 each  source registers of the instruction in ID.
REQ-006 useRn_ID, useRm_ID  in  1 each  ID instruction actually reads Rn / Rm.
REQ-007 flagUse_ID  in  1  ID instruction is a conditional branch consuming flags.
REQ-008 targetReg_EX  in  5  destination of the instruction in EX.
REQ-009 memRead_EX, RegWrite_EX, set_flags_EX  in  1 each  EX-stage control bits.
REQ-010 brTaken_EX  in  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  in  1  data memory not ready; whole pipeline must freeze.
REQ-012 pc_en, if_id_en  out  1 each  PC and IF/ID register write enables.
REQ-013 id_ex_bubble  out  1  force all ID/EX control bits to 0 (NOP insert).
REQ-014 if_id_flush, id_ex_flush  out  1 each  clear IF/ID and ID/EX contents.
REQ-015 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
REQ-017 state_o  out  2  current FSM state, for debug.

Function
REQ-018 FSM states: RUN, MEM_WAIT, FLUSH.
REQ-019 Load-use hazard (LU): memRead_EX & targetReg_EX!=31 & ((useRn_ID & Rn_ID==targetReg_EX) | (useRm_ID & Rm_ID==targetReg_EX)).
REQ-020 Flag hazard (FH): flagUse_ID & set_flags_EX.
REQ-021 Register 31 (XZR) never causes a hazard.
REQ-022 Priority in RUN: mem_busy > brTaken_EX > LU > FH.
REQ-023 RUN with mem_busy: freeze=1, pc_en=0, if_id_en=0; next state MEM_WAIT.
REQ-024 MEM_WAIT: outputs as in REQ-023 while mem_busy=1; when mem_busy=0, same outputs held for that cycle, next RUN.
REQ-025 RUN with brTaken_EX: if_id_flush=1, id_ex_flush=1, pc_en=1; next FLUSH; flush_cnt +1.
REQ-026 FLUSH: id_ex_bubble=1 for exactly one cycle, pc_en=1, if_id_en=1, LU/FH ignored; next RUN.
REQ-027 mem_busy in FLUSH: FLUSH outputs replaced by REQ-023 outputs; next MEM_WAIT; pending bubble is dropped.
REQ-028 RUN with LU or FH, no higher-priority event: pc_en=0, if_id_en=0, id_ex_bubble=1 for one cycle; stall_cnt +1; stay RUN.
REQ-029 LU and FH together: one stall cycle and one count only.
REQ-030 RUN, no event: pc_en=1, if_id_en=1, all other outputs 0.
REQ-031 Outputs are combinational from state and current inputs; zero-cycle latency.
REQ-032 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-033 stall_cnt does not count MEM_WAIT cycles.

Reset
REQ-034 While reset=1: state RUN, counters 0, pc_en=0, if_id_en=0, id_ex_bubble=1, both flushes=1, freeze=0, independent of clk.
REQ-035 On deassertion, the first rising edge operates from RUN.
REQ-036 Reset asserted in MEM_WAIT or FLUSH abandons the state with no residual stall or bubble.

Structure
REQ-037 Package hazard_pkg holds the state enum (RUN=0, MEM_WAIT=1, FLUSH=2), XZR=5'd31 and the default CNT_W.
REQ-038 Sub-module sat_counter (parameter CNT_W, inputs clk, reset, inc; output count) is instantiated twice.

Verification
REQ-039 LDUR X2 in EX (memRead_EX=1, targetReg_EX=2), ADD reading Rn_ID=2 -> one cycle with pc_en=0, id_ex_bubble=1, stall_cnt=1; next cycle pc_en=1.
REQ-040 Same as REQ-039 but targetReg_EX=31 and Rn_ID=31 -> no stall, stall_cnt=0.
REQ-041 brTaken_EX=1 in RUN -> both flushes=1 that cycle, then FLUSH with id_ex_bubble=1 for one cycle, then RUN; flush_cnt=1.
REQ-042 mem_busy=1 for 3 cycles together with LU -> freeze=1 for 4 cycles, no bubble, stall_cnt=0, then RUN.
REQ-043 CNT_W=2, five back-to-back LU events -> stall_cnt saturates at 3.
REQ-044 reset pulsed mid-MEM_WAIT -> state_o=RUN and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Purpose : shared types and constants for the pipeline hazard controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Default width of the stall / flush event counters.
    localparam int CNT_W_DEF = 16;

    // Register 31 reads as zero, so it can never carry a real dependency.
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Purpose : saturating up-counter for hazard event statistics.
// Latency : count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is ignored once the counter reaches all-ones.
//
// Ports: clk, reset (async, active-high), inc (count one event), count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard control: load-use / flag stalls, taken-branch
//           flush, and whole-pipe freeze while data memory is busy.
// Latency : all control outputs are combinational from state and inputs.
// Backpressure: mem_busy freezes the pipe; hazards stall PC and IF/ID.
//
// Ports:
//   clk, reset                  single clock, async active-high reset
//   Rn_ID/Rm_ID, useRn/useRm_ID ID-stage sources and their use bits
//   flagUse_ID                  ID instruction consumes condition flags
//   targetReg_EX, memRead_EX,
//   RegWrite_EX, set_flags_EX   EX-stage destination and control bits
//   brTaken_EX                  branch resolved taken in EX
//   mem_busy                    data memory not ready
//   pc_en, if_id_en             PC and IF/ID write enables
//   id_ex_bubble                zero ID/EX control bits
//   if_id_flush, id_ex_flush    clear IF/ID and ID/EX
//   freeze                      hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt        saturating event counters
//   state_o                     current FSM state
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             useRn_ID,
    input  logic             useRm_ID,
    input  logic             flagUse_ID,
    input  logic [4:0]       targetReg_EX,
    input  logic             memRead_EX,
    input  logic             RegWrite_EX,
    input  logic             set_flags_EX,
    input  logic             brTaken_EX,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    hz_state_t state;
    hz_state_t state_nxt;
    logic      lu_hz;
    logic      fh_hz;
    logic      stall_inc;
    logic      flush_inc;

    // A load's result is only available after MEM, so a dependent ID
    // instruction must wait a cycle. Loads into XZR write nothing.
    assign lu_hz = memRead_EX && (targetReg_EX != XZR) &&
                   ((useRn_ID && (Rn_ID == targetReg_EX)) ||
                    (useRm_ID && (Rm_ID == targetReg_EX)));

    assign fh_hz = flagUse_ID && set_flags_EX;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        freeze       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_nxt    = state;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (brTaken_EX) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pc_en       = 1'b1;
                    flush_inc   = 1'b1;
                    state_nxt   = FLUSH;
                end else if (lu_hz || fh_hz) begin
                    // Both hazards together still cost a single stall.
                    id_ex_bubble = 1'b1;
                    stall_inc    = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Freeze is held through the cycle mem_busy drops so the
                // returning data is captured before the pipe moves again.
                freeze = 1'b1;
                if (!mem_busy) begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // The pending bubble is dropped if memory stalls here; the
                // flushed registers already hold no valid instruction.
                if (mem_busy) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    id_ex_bubble = 1'b1;
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    state_nxt    = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Reset forces a safe, fully-flushed pipe regardless of clock.
        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            freeze       = 1'b0;
            stall_inc    = 1'b0;
            flush_inc    = 1'b0;
            state_nxt    = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_o = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    // RegWrite_EX is part of the EX control bundle but a load-use hazard
    // is keyed on memRead_EX alone, so it does not enter any decision.
    logic unused_ok;
    assign unused_ok = RegWrite_EX;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed self-checking bench for hazard_ctrl.
// Latency : n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Rn_ID, Rm_ID, targetReg_EX;
    logic       useRn_ID, useRm_ID, flagUse_ID;
    logic       memRead_EX, RegWrite_EX, set_flags_EX, brTaken_EX, mem_busy;

    logic        pc_en, if_id_en, id_ex_bubble, if_id_flush, id_ex_flush, freeze;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state_o;

    logic        w2_pc_en, w2_if_id_en, w2_bubble, w2_if_flush, w2_ex_flush, w2_freeze;
    logic [1:0]  w2_stall_cnt, w2_flush_cnt;
    logic [1:0]  w2_state_o;

    // {pc_en, if_id_en, id_ex_bubble, if_id_flush, id_ex_flush, freeze}
    wire [5:0] o = {pc_en, if_id_en, id_ex_bubble, if_id_flush, id_ex_flush, freeze};

    always #5 clk = ~clk;

    hazard_ctrl u_dut (
        .clk(clk), .reset(reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
        .flagUse_ID(flagUse_ID), .targetReg_EX(targetReg_EX),
        .memRead_EX(memRead_EX), .RegWrite_EX(RegWrite_EX),
        .set_flags_EX(set_flags_EX), .brTaken_EX(brTaken_EX), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    hazard_ctrl #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
        .flagUse_ID(flagUse_ID), .targetReg_EX(targetReg_EX),
        .memRead_EX(memRead_EX), .RegWrite_EX(RegWrite_EX),
        .set_flags_EX(set_flags_EX), .brTaken_EX(brTaken_EX), .mem_busy(mem_busy),
        .pc_en(w2_pc_en), .if_id_en(w2_if_id_en), .id_ex_bubble(w2_bubble),
        .if_id_flush(w2_if_flush), .id_ex_flush(w2_ex_flush), .freeze(w2_freeze),
        .stall_cnt(w2_stall_cnt), .flush_cnt(w2_flush_cnt), .state_o(w2_state_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clr_in();
        Rn_ID = 5'd0; Rm_ID = 5'd0; targetReg_EX = 5'd0;
        useRn_ID = 1'b0; useRm_ID = 1'b0; flagUse_ID = 1'b0;
        memRead_EX = 1'b0; RegWrite_EX = 1'b0; set_flags_EX = 1'b0;
        brTaken_EX = 1'b0; mem_busy = 1'b0;
    endtask

    // LDUR into reg r in EX, ADD reading r through Rn in ID.
    task automatic set_lu(input logic [4:0] r);
        memRead_EX = 1'b1; RegWrite_EX = 1'b1; targetReg_EX = r;
        Rn_ID = r; useRn_ID = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr_in();
        reset = 1'b1;
        #7;
        chk("rst_outs", 32'(o), 32'b001110);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);

        @(negedge clk); reset = 1'b0; #2;
        chk("run_idle", 32'(o), 32'b110000);

        // Load-use via Rn
        @(negedge clk); set_lu(5'd2); #2;
        chk("lu_outs", 32'(o), 32'b001000);
        chk("lu_state", 32'(state_o), 32'd0);
        @(posedge clk); #1;
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        @(negedge clk); clr_in(); #2;
        chk("lu_release", 32'(o), 32'b110000);

        // XZR never hazards
        @(negedge clk); set_lu(5'd31); #2;
        chk("xzr_outs", 32'(o), 32'b110000);
        @(posedge clk); #1;
        chk("xzr_cnt", 32'(stall_cnt), 32'd1);

        // Rm match only counts when Rm is actually read
        @(negedge clk); clr_in();
        memRead_EX = 1'b1; targetReg_EX = 5'd5; Rm_ID = 5'd5; useRm_ID = 1'b0; #2;
        chk("rm_unused", 32'(o), 32'b110000);
        useRm_ID = 1'b1; #1;
        chk("rm_outs", 32'(o), 32'b001000);
        @(posedge clk); #1;
        chk("rm_cnt", 32'(stall_cnt), 32'd2);

        // LU and FH together: one stall, one count
        @(negedge clk); flagUse_ID = 1'b1; set_flags_EX = 1'b1; #2;
        chk("lufh_outs", 32'(o), 32'b001000);
        @(posedge clk); #1;
        chk("lufh_cnt", 32'(stall_cnt), 32'd3);

        // FH alone
        @(negedge clk); clr_in(); flagUse_ID = 1'b1; set_flags_EX = 1'b1; #2;
        chk("fh_outs", 32'(o), 32'b001000);
        @(posedge clk); #1;
        chk("fh_cnt", 32'(stall_cnt), 32'd4);

        // Taken branch beats a pending load-use
        @(negedge clk); clr_in(); brTaken_EX = 1'b1; set_lu(5'd3); #2;
        chk("br_outs", 32'(o), 32'b100110);
        @(posedge clk); #1;
        chk("br_state", 32'(state_o), 32'd2);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        @(negedge clk); brTaken_EX = 1'b0; #2;
        chk("flush_outs", 32'(o), 32'b111000);
        @(posedge clk); #1;
        chk("flush_exit", 32'(state_o), 32'd0);
        chk("flush_no_stall", 32'(stall_cnt), 32'd4);
        @(negedge clk); clr_in(); #2;
        chk("post_flush_idle", 32'(o), 32'b110000);

        // mem_busy arriving in FLUSH drops the bubble
        @(negedge clk); brTaken_EX = 1'b1;
        @(negedge clk); brTaken_EX = 1'b0; mem_busy = 1'b1; #2;
        chk("fl_busy_outs", 32'(o), 32'b000001);
        @(posedge clk); #1;
        chk("fl_busy_state", 32'(state_o), 32'd1);
        chk("fl_busy_fcnt", 32'(flush_cnt), 32'd2);
        @(negedge clk); mem_busy = 1'b0; #2;
        chk("mw_exit_outs", 32'(o), 32'b000001);
        @(posedge clk); #1;
        chk("mw_exit_state", 32'(state_o), 32'd0);

        // mem_busy 3 cycles with load-use: 4 freeze cycles, no bubble, no count
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_lu(5'd7); mem_busy = (i < 3); #2;
            chk($sformatf("mw_freeze%0d", i), 32'(o), 32'b000001);
        end
        @(posedge clk); #1;
        chk("mw_done_state", 32'(state_o), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        @(negedge clk); clr_in(); #2;
        chk("mw_idle", 32'(o), 32'b110000);

        // Async reset in the middle of MEM_WAIT
        @(negedge clk); mem_busy = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(state_o), 32'd1);
        @(negedge clk); #2; reset = 1'b1; #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_flush", 32'(flush_cnt), 32'd0);
        chk("arst_w2_stall", 32'(w2_stall_cnt), 32'd0);
        chk("arst_outs", 32'(o), 32'b001110);
        @(negedge clk); reset = 1'b0; mem_busy = 1'b0; #2;
        chk("arst_run", 32'(o), 32'b110000);
        @(posedge clk); #1;
        chk("arst_stays_run", 32'(state_o), 32'd0);

        // Five back-to-back load-use events: 2-bit counter saturates at 3
        @(negedge clk); set_lu(5'd9);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_w2", 32'(w2_stall_cnt), 32'd3);
        chk("sat_w16", 32'(stall_cnt), 32'd5);
        @(negedge clk); clr_in();
        @(posedge clk); #1;
        chk("sat_hold_w2", 32'(w2_stall_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
